axi4_rrch_sender_burst: RTL and testbench

AXI4 read-data (R) channel sender that merges upstream R beats with locally generated error responses for dropped read transactions.
- Drop requests are queued in a parametrised FIFO. Each carries ID, burst length and error code.
- Each request produces a full error burst of len+1 beats, with RLAST on the final beat.
- Error bursts are inserted only between upstream bursts, never interleaved inside one.
- Sits between the RAB miss/protection logic (drop requests) and the slave-side R port.

---
 rtl/axi4_rrch_sender_burst.sv | 174 +++++++++++++++++
 tb/tb_axi4_rrch_sender_burst.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_rrch_sender_burst.sv
// AXI4 R-channel sender: forwards upstream R bursts and inserts queued error bursts
// for dropped read transactions, only at upstream burst boundaries.
module axi4_rrch_sender_burst #(
  parameter int unsigned C_AXI_DATA_WIDTH  = 32,
  parameter int unsigned C_AXI_ID_WIDTH    = 4,
  parameter int unsigned C_AXI_USER_WIDTH  = 4,
  parameter int unsigned C_DROP_FIFO_DEPTH = 4
) (
  input  logic                                       axi4_aclk,
  input  logic                                       axi4_arstn,

  input  logic                                       trans_drop,
  output logic                                       trans_drop_ready,
  input  logic [C_AXI_ID_WIDTH-1:0]                  trans_id,
  input  logic [7:0]                                 trans_len,
  input  logic                                       trans_decerr,
  output logic [$clog2(C_DROP_FIFO_DEPTH+1)-1:0]     drop_count,
  output logic                                       drop_busy,

  output logic [C_AXI_ID_WIDTH-1:0]                  s_axi4_rid,
  output logic [C_AXI_DATA_WIDTH-1:0]                s_axi4_rdata,
  output logic [1:0]                                 s_axi4_rresp,
  output logic                                       s_axi4_rlast,
  output logic [C_AXI_USER_WIDTH-1:0]                s_axi4_ruser,
  output logic                                       s_axi4_rvalid,
  input  logic                                       s_axi4_rready,

  input  logic [C_AXI_ID_WIDTH-1:0]                  m_axi4_rid,
  input  logic [C_AXI_DATA_WIDTH-1:0]                m_axi4_rdata,
  input  logic [1:0]                                 m_axi4_rresp,
  input  logic                                       m_axi4_rlast,
  input  logic [C_AXI_USER_WIDTH-1:0]                m_axi4_ruser,
  input  logic                                       m_axi4_rvalid,
  output logic                                       m_axi4_rready
);

  localparam int unsigned CntW = $clog2(C_DROP_FIFO_DEPTH + 1);
  localparam int unsigned PtrW = $clog2(C_DROP_FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StPass, StDrop} state_e;

  state_e state_q, state_d;
  logic [7:0] cnt_q, cnt_d;

  logic [C_AXI_ID_WIDTH-1:0] fifo_id_q  [C_DROP_FIFO_DEPTH];
  logic [7:0]                fifo_len_q [C_DROP_FIFO_DEPTH];
  logic                      fifo_dec_q [C_DROP_FIFO_DEPTH];

  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_nxt;
  logic [CntW-1:0] count_q, count_d;
  logic            fifo_empty, fifo_full;
  logic            push, pop;

  logic [C_AXI_ID_WIDTH-1:0] head_id;
  logic [7:0]                head_len, next_len;
  logic                      head_dec;

  assign fifo_empty       = (count_q == '0);
  assign fifo_full        = (count_q == CntW'(C_DROP_FIFO_DEPTH));
  assign trans_drop_ready = ~fifo_full;
  assign drop_count       = count_q;
  assign push             = trans_drop & trans_drop_ready;

  assign rd_ptr_nxt = rd_ptr_q + PtrW'(1);
  assign head_id    = fifo_id_q[rd_ptr_q];
  assign head_len   = fifo_len_q[rd_ptr_q];
  assign head_dec   = fifo_dec_q[rd_ptr_q];
  assign next_len   = fifo_len_q[rd_ptr_nxt];

  // Entry storage needs no reset: only slots below count_q are ever read.
  always_ff @(posedge axi4_aclk) begin
    if (push) begin
      fifo_id_q[wr_ptr_q]  <= trans_id;
      fifo_len_q[wr_ptr_q] <= trans_len;
      fifo_dec_q[wr_ptr_q] <= trans_decerr;
    end
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pop           = 1'b0;
    drop_busy     = 1'b0;
    s_axi4_rid    = m_axi4_rid;
    s_axi4_rdata  = m_axi4_rdata;
    s_axi4_rresp  = m_axi4_rresp;
    s_axi4_rlast  = m_axi4_rlast;
    s_axi4_ruser  = m_axi4_ruser;
    s_axi4_rvalid = m_axi4_rvalid;
    m_axi4_rready = s_axi4_rready;

    unique case (state_q)
      StIdle: begin
        // Upstream wins when both are pending.
        if (m_axi4_rvalid) begin
          if (s_axi4_rready && !m_axi4_rlast) begin
            state_d = StPass;
          end
        end else if (!fifo_empty) begin
          state_d = StDrop;
          cnt_d   = head_len;
        end
      end

      StPass: begin
        if (m_axi4_rvalid && s_axi4_rready && m_axi4_rlast) begin
          if (!fifo_empty) begin
            state_d = StDrop;
            cnt_d   = head_len;
          end else begin
            state_d = StIdle;
          end
        end
      end

      StDrop: begin
        drop_busy     = 1'b1;
        s_axi4_rvalid = 1'b1;
        m_axi4_rready = 1'b0;
        s_axi4_rid    = head_id;
        s_axi4_rdata  = '0;
        s_axi4_ruser  = '0;
        s_axi4_rresp  = head_dec ? 2'b11 : 2'b10;
        s_axi4_rlast  = (cnt_q == 8'd0);
        if (s_axi4_rready) begin
          if (cnt_q != 8'd0) begin
            cnt_d = cnt_q - 8'd1;
          end else begin
            pop = 1'b1;
            // Chain straight into the next queued burst only if upstream is quiet.
            if (count_q > CntW'(1) && !m_axi4_rvalid) begin
              state_d = StDrop;
              cnt_d   = next_len;
            end else begin
              state_d = StIdle;
            end
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
    if (!axi4_arstn) begin
      state_q  <= StIdle;
      cnt_q    <= 8'd0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      count_q <= count_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_nxt;
      end
    end
  end

endmodule

// File: tb/tb_axi4_rrch_sender_burst.sv
// Randomized and directed bench for axi4_rrch_sender_burst against a queue-based
// model of the error-burst insertion rules.
module tb_axi4_rrch_sender_burst;

  localparam int unsigned DW    = 32;
  localparam int unsigned IW    = 4;
  localparam int unsigned UW    = 4;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic          axi4_aclk = 1'b0;
  logic          axi4_arstn;
  logic          trans_drop;
  logic          trans_drop_ready;
  logic [IW-1:0] trans_id;
  logic [7:0]    trans_len;
  logic          trans_decerr;
  logic [CW-1:0] drop_count;
  logic          drop_busy;
  logic [IW-1:0] s_rid, m_rid;
  logic [DW-1:0] s_rdata, m_rdata;
  logic [1:0]    s_rresp, m_rresp;
  logic          s_rlast, m_rlast;
  logic [UW-1:0] s_ruser, m_ruser;
  logic          s_rvalid, m_rvalid;
  logic          s_rready, m_rready;

  axi4_rrch_sender_burst #(
    .C_AXI_DATA_WIDTH (DW),
    .C_AXI_ID_WIDTH   (IW),
    .C_AXI_USER_WIDTH (UW),
    .C_DROP_FIFO_DEPTH(DEPTH)
  ) dut (
    .axi4_aclk       (axi4_aclk),
    .axi4_arstn      (axi4_arstn),
    .trans_drop      (trans_drop),
    .trans_drop_ready(trans_drop_ready),
    .trans_id        (trans_id),
    .trans_len       (trans_len),
    .trans_decerr    (trans_decerr),
    .drop_count      (drop_count),
    .drop_busy       (drop_busy),
    .s_axi4_rid      (s_rid),
    .s_axi4_rdata    (s_rdata),
    .s_axi4_rresp    (s_rresp),
    .s_axi4_rlast    (s_rlast),
    .s_axi4_ruser    (s_ruser),
    .s_axi4_rvalid   (s_rvalid),
    .s_axi4_rready   (s_rready),
    .m_axi4_rid      (m_rid),
    .m_axi4_rdata    (m_rdata),
    .m_axi4_rresp    (m_rresp),
    .m_axi4_rlast    (m_rlast),
    .m_axi4_ruser    (m_ruser),
    .m_axi4_rvalid   (m_rvalid),
    .m_axi4_rready   (m_rready)
  );

  always #5 axi4_aclk = ~axi4_aclk;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [7:0]    len;
    logic          dec;
  } drop_t;

  // Model: pending drops, whether an upstream burst is open, and beats left in the
  // error burst being sent (0 when none).
  drop_t dq[$];
  bit    in_burst;
  int    beats_left;

  int n_checks = 0;
  int n_errors = 0;
  int err_hs   = 0;
  int err_last = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic compare();
    logic          exp_v, exp_mr;
    logic [63:0]   exp_beat;
    if (beats_left > 0) begin
      exp_v    = 1'b1;
      exp_mr   = 1'b0;
      exp_beat = {dq[0].id, (dq[0].dec ? 2'b11 : 2'b10), (beats_left == 1), 32'h0, 4'h0};
    end else begin
      exp_v    = m_rvalid;
      exp_mr   = s_rready;
      exp_beat = {m_rid, m_rresp, m_rlast, m_rdata, m_ruser};
    end
    check("s_rvalid", s_rvalid, exp_v);
    check("s_beat", {s_rid, s_rresp, s_rlast, s_rdata, s_ruser}, exp_beat);
    check("m_rready", m_rready, exp_mr);
    check("drop_count", drop_count, dq.size());
    check("drop_ready", trans_drop_ready, dq.size() < DEPTH);
    check("drop_busy", drop_busy, beats_left > 0);
  endtask

  // Advance the model across the coming clock edge using the inputs now applied.
  task automatic model_step();
    int size_before = dq.size();
    if (beats_left > 0) begin
      if (s_rready) begin
        if (beats_left > 1) begin
          beats_left--;
        end else begin
          void'(dq.pop_front());
          beats_left = (dq.size() > 0 && !m_rvalid) ? int'(dq[0].len) + 1 : 0;
        end
      end
    end else if (m_rvalid) begin
      if (s_rready) begin
        if (!m_rlast) begin
          in_burst = 1'b1;
        end else if (in_burst) begin
          in_burst = 1'b0;
          if (dq.size() > 0) beats_left = int'(dq[0].len) + 1;
        end
      end
    end else if (!in_burst && dq.size() > 0) begin
      beats_left = int'(dq[0].len) + 1;
    end
    if (trans_drop && size_before < DEPTH) begin
      dq.push_back('{id: trans_id, len: trans_len, dec: trans_decerr});
    end
  endtask

  task automatic cycle(input bit drop, input logic [IW-1:0] id, input logic [7:0] len,
                       input bit dec, input bit mv, input bit ml, input bit sr);
    @(negedge axi4_aclk);
    trans_drop   = drop;
    trans_id     = id;
    trans_len    = len;
    trans_decerr = dec;
    m_rvalid     = mv;
    m_rlast      = ml;
    m_rid        = IW'($urandom);
    m_rdata      = $urandom;
    m_rresp      = 2'($urandom);
    m_ruser      = UW'($urandom);
    s_rready     = sr;
    #1;
    compare();
    if (drop_busy && s_rvalid && s_rready) begin
      err_hs++;
      if (s_rlast) err_last++;
    end
    model_step();
  endtask

  task automatic idle_inputs();
    trans_drop = 1'b0;
    m_rvalid   = 1'b0;
    m_rlast    = 1'b0;
    s_rready   = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge axi4_aclk);
    idle_inputs();
    axi4_arstn = 1'b0;
    #1;
    check("rst_count", drop_count, 0);
    check("rst_busy", drop_busy, 0);
    check("rst_ready", trans_drop_ready, 1);
    check("rst_rvalid", s_rvalid, m_rvalid);
    check("rst_rready", m_rready, s_rready);
    dq.delete();
    in_burst   = 1'b0;
    beats_left = 0;
    @(negedge axi4_aclk);
    axi4_arstn = 1'b1;
  endtask

  initial begin
    axi4_arstn   = 1'b0;
    trans_id     = '0;
    trans_len    = '0;
    trans_decerr = 1'b0;
    m_rid        = '0;
    m_rdata      = '0;
    m_rresp      = '0;
    m_ruser      = '0;
    idle_inputs();
    in_burst   = 1'b0;
    beats_left = 0;
    do_reset();

    // Single-beat SLVERR burst.
    err_hs = 0; err_last = 0;
    cycle(1'b1, 4'd3, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (4) cycle(1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("p1_beats", err_hs, 1);
    check("p1_last", err_last, 1);

    // Four-beat DECERR burst with a stalling consumer.
    err_hs = 0; err_last = 0;
    cycle(1'b1, 4'd5, 8'd3, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 12; i++) cycle(1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'(i % 2));
    check("p2_beats", err_hs, 4);
    check("p2_last", err_last, 1);

    // Drop arriving mid upstream burst waits for the upstream rlast.
    cycle(1'b0, 4'd0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    cycle(1'b0, 4'd0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 4'd7, 8'd1, 1'b0, 1'b1, 1'b0, 1'b1);
    cycle(1'b0, 4'd0, 8'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    repeat (4) cycle(1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Overfill the FIFO, then drain in order.
    for (int i = 1; i <= 5; i++) cycle(1'b1, 4'(i), 8'(i % 3), 1'(i % 2), 1'b0, 1'b0, 1'b0);
    check("p4_full", trans_drop_ready, 0);
    repeat (16) cycle(1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Back-to-back upstream bursts with drops pending.
    for (int i = 0; i < 36; i++) begin
      cycle(1'(i % 6 == 0), 4'(i), 8'd1, 1'b1, 1'b1, 1'(i % 3 == 2), 1'b1);
    end
    repeat (8) cycle(1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Maximum-length burst: 256 beats, rlast only once.
    err_hs = 0; err_last = 0;
    cycle(1'b1, 4'd9, 8'd255, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (262) cycle(1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("max_beats", err_hs, 256);
    check("max_last", err_last, 1);

    // Reset in the middle of an eight-beat error burst.
    cycle(1'b1, 4'd2, 8'd7, 1'b1, 1'b0, 1'b0, 1'b1);
    repeat (3) cycle(1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    do_reset();
    err_hs = 0;
    for (int i = 0; i < 12; i++) cycle(1'b0, 4'd0, 8'd0, 1'b0, 1'(i % 2), 1'b1, 1'b1);
    check("rst_residue", err_hs, 0);

    // Random traffic with one reset in the middle.
    for (int i = 0; i < 4000; i++) begin
      logic [7:0] l;
      l = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 5));
      cycle(($urandom_range(0, 7) == 0), IW'($urandom), l, 1'($urandom),
            ($urandom_range(0, 1) == 1), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 3) != 0));
      if (i == 2000) do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
